// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E core: valid/ready fetch, single-cycle EXEC, sticky trap.
// Optional ebreak halt is enabled by defining RV32_CORE_EBREAK_HALT_EN.
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned NR_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] retire_inst,
    output logic        illegal,
    output logic        halt,
    output logic [31:0] a0
);
    localparam int unsigned RW = $clog2(NR_REGS);

    typedef enum logic [2:0] {IDLE, FETCH_REQ, FETCH_WAIT, EXEC, TRAP, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] inst;
    logic [31:0] regs [NR_REGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4, next_pc, wb_val;
    logic        legal, uses_rs1, uses_rs2, uses_rd, wb_en, taken, is_ebreak;
    logic        trap_now, commit;

    function automatic logic idx_ok(input logic [4:0] i);
        return 32'(i) < NR_REGS;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign f3       = inst[14:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];
    assign f7       = inst[31:25];
    assign imm_i    = {{20{inst[31]}}, inst[31:20]};
    assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u    = {inst[31:12], 12'b0};
    assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign rs1_val  = regs[rs1[RW-1:0]];
    assign rs2_val  = regs[rs2[RW-1:0]];
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        case (f3)
            3'b000:  taken = rs1_val == rs2_val;
            3'b001:  taken = rs1_val != rs2_val;
            3'b100:  taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val < rs2_val;
            default: taken = rs1_val >= rs2_val;
        endcase
    end

    always_comb begin
        legal     = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        uses_rd   = 1'b0;
        wb_en     = 1'b0;
        wb_val    = '0;
        next_pc   = pc_plus4;
        is_ebreak = 1'b0;
        case (opcode)
            7'b0110111: begin
                legal = 1'b1; uses_rd = 1'b1; wb_en = 1'b1; wb_val = imm_u;
            end
            7'b0010111: begin
                legal = 1'b1; uses_rd = 1'b1; wb_en = 1'b1; wb_val = pc + imm_u;
            end
            7'b1101111: begin
                legal = 1'b1; uses_rd = 1'b1; wb_en = 1'b1; wb_val = pc_plus4;
                next_pc = pc + imm_j;
            end
            7'b1100111: begin
                legal = (f3 == 3'b000); uses_rs1 = 1'b1; uses_rd = 1'b1;
                wb_en = 1'b1; wb_val = pc_plus4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            7'b1100011: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (taken) next_pc = pc + imm_b;
            end
            7'b0010011: begin
                case (f3)
                    3'b001:  legal = (f7 == 7'b0000000);
                    3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
                uses_rs1 = 1'b1; uses_rd = 1'b1; wb_en = 1'b1;
                // bit 30 selects SRAI only; for ADDI it is just immediate data
                wb_val = alu(f3, (f3 == 3'b101) && inst[30], rs1_val, imm_i);
            end
            7'b0110011: begin
                legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1; wb_en = 1'b1;
                wb_val = alu(f3, inst[30], rs1_val, rs2_val);
            end
            default: legal = 1'b0;
        endcase
`ifdef RV32_CORE_EBREAK_HALT_EN
        if (inst == 32'h0010_0073) begin
            legal = 1'b1; is_ebreak = 1'b1;
        end
`endif
    end

    assign trap_now = !legal || next_pc[1] ||
                      (uses_rs1 && !idx_ok(rs1)) ||
                      (uses_rs2 && !idx_ok(rs2)) ||
                      (uses_rd  && !idx_ok(rd));
    assign commit   = (state == EXEC) && !trap_now;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = FETCH_REQ;
            FETCH_REQ:  if (imem_req_ready) state_n = FETCH_WAIT;
            FETCH_WAIT: if (imem_resp_valid) state_n = EXEC;
            EXEC:       state_n = trap_now ? TRAP : (is_ebreak ? HALT : FETCH_REQ);
            default:    state_n = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
            for (int unsigned i = 0; i < NR_REGS; i++) regs[i] <= '0;
        end else begin
            state <= state_n;
            if (state == FETCH_WAIT && imem_resp_valid) inst <= imem_resp_data;
            if (commit) begin
                pc <= next_pc;
                if (wb_en && rd != 5'd0) regs[rd[RW-1:0]] <= wb_val;
            end
        end
    end

    assign imem_req_valid = (state == FETCH_REQ);
    assign imem_addr      = pc;
    assign retire         = commit;
    assign retire_inst    = commit ? inst : '0;
    assign illegal        = (state == TRAP);
    assign a0             = regs[10];
`ifdef RV32_CORE_EBREAK_HALT_EN
    assign halt = (state == HALT);
`else
    assign halt = 1'b0;
`endif
endmodule
